// File: rtl/bound_flasher_ctrl_if.sv
// Bound flasher controller bus: flick request in,
// lamp bar, counter and next-counter controls out.
interface bound_flasher_ctrl_if;
  logic        flick;
  logic [15:0] lamps;
  logic [4:0]  counter;
  logic [1:0]  count_state;
  logic [4:0]  counter_load;
  logic        counter_load_en;

  modport master (
    output flick,
    input  lamps,
    input  counter,
    input  count_state,
    input  counter_load,
    input  counter_load_en
  );

  modport slave (
    input  flick,
    output lamps,
    output counter,
    output count_state,
    output counter_load,
    output counter_load_en
  );
endinterface

// File: rtl/bound_flasher_ctrl.sv
// Bound flasher sequencer: walks up/down/kickback/blink
// pattern and owns the 5-bit lamp counter.
module bound_flasher_ctrl #(
  parameter int BLINK_COUNT = 2
) (
  input logic                 clk,
  input logic                 rst,
  bound_flasher_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE,
    UP1,
    DOWN1,
    UP2,
    DOWN2,
    UP3,
    DOWN3,
    BLINK_ON,
    BLINK_OFF
  } state_t;

  localparam logic [1:0] COUNT_DIS     = 2'b00;
  localparam logic [1:0] COUNT_UP_EN   = 2'b01;
  localparam logic [1:0] COUNT_DOWN_EN = 2'b10;
  localparam logic [1:0] COUNT_HOLD    = 2'b11;
  localparam logic [1:0] BLINK_LAST    = 2'(BLINK_COUNT - 1);

  state_t      state;
  state_t      state_n;
  logic [4:0]  counter;
  logic [4:0]  counter_n;
  logic [1:0]  blink_cnt;
  logic [1:0]  cs;
  logic [4:0]  ld;
  logic        ld_en;
  logic        kick;
  logic [15:0] lamps;

  assign kick = bus.flick &&
                (counter == 5'd6 || counter == 5'd11);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (bus.flick) state_n = UP1;
      UP1:       if (counter == 5'd6) state_n = DOWN1;
      DOWN1:     if (counter == 5'd0) state_n = UP2;
      UP2: begin
        if (kick) state_n = DOWN1;
        else if (counter == 5'd11) state_n = DOWN2;
      end
      DOWN2:     if (counter == 5'd5) state_n = UP3;
      UP3: begin
        if (kick) state_n = DOWN2;
        else if (counter == 5'd16) state_n = DOWN3;
      end
      DOWN3:     if (counter == 5'd0) state_n = BLINK_ON;
      BLINK_ON:  state_n = BLINK_OFF;
      BLINK_OFF: begin
        if (blink_cnt == BLINK_LAST) state_n = IDLE;
        else state_n = BLINK_ON;
      end
      default:   state_n = IDLE;
    endcase
  end

  // Controls look ahead at state_n so the turn-around
  // happens in the cycle the target is reached.
  always_comb begin
    cs    = COUNT_DIS;
    ld    = 5'd0;
    ld_en = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        state_n == UP1,
        state_n == UP2,
        state_n == UP3:       cs = COUNT_UP_EN;
        state_n == DOWN1,
        state_n == DOWN2,
        state_n == DOWN3:     cs = COUNT_DOWN_EN;
        state_n == BLINK_ON: begin
          cs    = COUNT_HOLD;
          ld    = 5'd16;
          ld_en = 1'b1;
        end
        state_n == BLINK_OFF: begin
          cs    = COUNT_HOLD;
          ld_en = 1'b1;
        end
        default:              cs = COUNT_DIS;
      endcase
    end
  end

  always_comb begin
    counter_n = counter;
    if (ld_en) begin
      counter_n = ld;
    end else begin
      case (cs)
        COUNT_DIS:     counter_n = 5'd0;
        COUNT_UP_EN:   counter_n = counter + 5'd1;
        COUNT_DOWN_EN: counter_n = counter - 5'd1;
        default:       counter_n = counter;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      counter   <= 5'd0;
      blink_cnt <= 2'd0;
    end else begin
      state   <= state_n;
      counter <= counter_n;
      if (state == BLINK_OFF) begin
        if (blink_cnt == BLINK_LAST) blink_cnt <= 2'd0;
        else blink_cnt <= blink_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    lamps = '0;
    for (int i = 0; i < 16; i++) begin
      lamps[i] = (5'(i) < counter);
    end
  end

  assign bus.lamps           = lamps;
  assign bus.counter         = counter;
  assign bus.count_state     = cs;
  assign bus.counter_load    = ld;
  assign bus.counter_load_en = ld_en;

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Directed bench for bound_flasher_ctrl: traces, kickbacks,
// reset and blink tail against hand-built counter tables.
module tb_bound_flasher_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  int          exp_q[$];
  int          hold_q[$];
  logic [1:0]  obs_cs[$];
  logic [4:0]  obs_ld[$];
  logic        obs_le[$];

  bound_flasher_ctrl_if b2 ();
  bound_flasher_ctrl_if b3 ();

  bound_flasher_ctrl #(.BLINK_COUNT(2)) dut2 (
    .clk (clk),
    .rst (rst),
    .bus (b2)
  );

  bound_flasher_ctrl #(.BLINK_COUNT(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (b3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] therm(input int c);
    return 16'((32'd1 << c) - 32'd1);
  endfunction

  function automatic logic [31:0] get_cnt(input bit sel);
    return sel ? 32'(b3.counter) : 32'(b2.counter);
  endfunction

  function automatic logic [31:0] get_lamps(input bit sel);
    return sel ? 32'(b3.lamps) : 32'(b2.lamps);
  endfunction

  task automatic drive(input bit sel, input logic v);
    if (sel) b3.flick = v;
    else b2.flick = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ramp(input int a, input int b);
    if (a <= b) for (int v = a; v <= b; v++) exp_q.push_back(v);
    else for (int v = a; v >= b; v--) exp_q.push_back(v);
  endtask

  task automatic blink_tail(input int nb);
    for (int k = 0; k < nb; k++) begin
      exp_q.push_back(16);
      exp_q.push_back(0);
    end
  endtask

  task automatic build_normal(input int nb);
    exp_q.delete();
    hold_q.delete();
    ramp(1, 6);
    ramp(5, 0);
    ramp(1, 11);
    ramp(10, 5);
    ramp(6, 16);
    ramp(15, 0);
    blink_tail(nb);
  endtask

  task automatic run_seq(input bit sel, input int n,
                         input string tag);
    int  lim;
    logic h;
    lim = (n < exp_q.size()) ? n : exp_q.size();
    obs_cs.delete();
    obs_ld.delete();
    obs_le.delete();
    drive(sel, 1'b1);
    for (int i = 0; i < lim; i++) begin
      step();
      chk($sformatf("%s[%0d].counter", tag, i),
          get_cnt(sel), 32'(exp_q[i]));
      chk($sformatf("%s[%0d].lamps", tag, i),
          get_lamps(sel), 32'(therm(exp_q[i])));
      obs_cs.push_back(sel ? b3.count_state : b2.count_state);
      obs_ld.push_back(sel ? b3.counter_load : b2.counter_load);
      obs_le.push_back(sel ? b3.counter_load_en
                           : b2.counter_load_en);
      h = 1'b0;
      foreach (hold_q[j]) if (hold_q[j] == i) h = 1'b1;
      drive(sel, h);
    end
    drive(sel, 1'b0);
  endtask

  task automatic idle_tail(input bit sel, input string tag);
    drive(sel, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk($sformatf("%s.idle%0d.counter", tag, i),
          get_cnt(sel), 32'd0);
      chk($sformatf("%s.idle%0d.cs", tag, i),
          sel ? 32'(b3.count_state) : 32'(b2.count_state),
          32'd0);
    end
  endtask

  initial begin
    b2.flick = 1'b0;
    b3.flick = 1'b0;
    #3;
    chk("reset.counter", 32'(b2.counter), 32'd0);
    chk("reset.lamps", 32'(b2.lamps), 32'd0);
    chk("reset.cs", 32'(b2.count_state), 32'd0);
    chk("reset.load_en", 32'(b2.counter_load_en), 32'd0);
    chk("reset.load", 32'(b2.counter_load), 32'd0);
    rst = 1'b0;

    // Normal sequence, then idle
    build_normal(2);
    run_seq(1'b0, 1000, "normal");
    chk("normal.cs_first", 32'(obs_cs[0]), 32'd1);
    chk("normal.cs_peak", 32'(obs_cs[5]), 32'd2);
    idle_tail(1'b0, "normal");

    // Reset mid-UP2 at counter 8
    build_normal(2);
    run_seq(1'b0, 20, "rst_pre");
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid.counter", 32'(b2.counter), 32'd0);
    chk("rst_mid.lamps", 32'(b2.lamps), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rst_idle%0d.counter", i),
          32'(b2.counter), 32'd0);
      chk($sformatf("rst_idle%0d.cs", i),
          32'(b2.count_state), 32'd0);
    end

    // UP2 kickback at 11
    exp_q.delete();
    hold_q.delete();
    ramp(1, 6);
    ramp(5, 0);
    ramp(1, 11);
    ramp(10, 0);
    ramp(1, 11);
    ramp(10, 5);
    ramp(6, 16);
    ramp(15, 0);
    blink_tail(2);
    hold_q.push_back(22);
    run_seq(1'b0, 1000, "kick_up2");
    idle_tail(1'b0, "kick_up2");

    // UP3 kickbacks at 6 then at 11
    exp_q.delete();
    hold_q.delete();
    ramp(1, 6);
    ramp(5, 0);
    ramp(1, 11);
    ramp(10, 5);
    ramp(6, 5);
    ramp(6, 11);
    ramp(10, 5);
    ramp(6, 16);
    ramp(15, 0);
    blink_tail(2);
    hold_q.push_back(29);
    hold_q.push_back(36);
    run_seq(1'b0, 1000, "kick_up3");
    idle_tail(1'b0, "kick_up3");

    // flick held through DOWN1, DOWN3 and blink
    build_normal(2);
    for (int i = 5; i <= 11; i++) hold_q.push_back(i);
    for (int i = 40; i <= 59; i++) hold_q.push_back(i);
    run_seq(1'b0, 1000, "ignored");
    idle_tail(1'b0, "ignored");

    // Three blink pairs
    build_normal(3);
    run_seq(1'b1, 1000, "blink3");
    chk("blink3.le_before", 32'(obs_le[54]), 32'd0);
    chk("blink3.le_exit", 32'(obs_le[55]), 32'd1);
    chk("blink3.ld_exit", 32'(obs_ld[55]), 32'd16);
    chk("blink3.le_on", 32'(obs_le[56]), 32'd1);
    chk("blink3.ld_on", 32'(obs_ld[56]), 32'd0);
    chk("blink3.le_last", 32'(obs_le[61]), 32'd0);
    chk("blink3.cs_last", 32'(obs_cs[61]), 32'd0);
    idle_tail(1'b1, "blink3");

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
